// File: rtl/timer_pkg.sv
// timer_pkg: shared types and defaults for the timer controller.
//   timer_state_e       - FSM state encoding (IDLE=0, RUN=1, PAUSED=2, DONE=3)
//   TIMER_WIDTH_DEFAULT - default counter/limit width
package timer_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_e;

  localparam int TIMER_WIDTH_DEFAULT = 3;
endpackage

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: control/status bundle between a timer user and timer_ctrl.
//   master: drives start/stop/pause/limit/periodic, observes status
//   slave : the timer side; observes controls, drives count/busy/done/wrap/state
interface timer_ctrl_if #(
  parameter int WIDTH = timer_pkg::TIMER_WIDTH_DEFAULT
);
  logic             start;
  logic             stop;
  logic             pause;
  logic [WIDTH-1:0] limit;
  logic             periodic;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             wrap;
  logic [1:0]       state;

  modport master (output start, stop, pause, limit, periodic,
                  input  count, busy, done, wrap, state);
  modport slave  (input  start, stop, pause, limit, periodic,
                  output count, busy, done, wrap, state);
endinterface

// File: rtl/timer_count_core.sv
// timer_count_core: WIDTH-bit up-counter with synchronous clear and enable.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : load zero on the next edge (wins over i_en)
//   i_en       : increment on the next edge
//   o_count    : registered count
module timer_count_core #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_en)  r_count <= r_count + WIDTH'(1);
  end

  assign o_count = r_count;
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: start/stop/pause sequencer around timer_count_core, with a
// terminal limit and one-shot or periodic mode.
//   clk, rst_n : clock, async active-low reset
//   bus        : timer_ctrl_if slave; start/stop/pause/limit/periodic in,
//                count/busy/done/wrap/state out (all registered or decoded
//                from registered state)
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  timer_ctrl_if.slave  bus
);
  timer_state_e     r_state;
  logic [WIDTH-1:0] r_limit_q;
  logic             r_periodic_q;
  logic             r_done;
  logic             r_wrap;

  logic [WIDTH-1:0] w_count;
  logic             w_clr;
  logic             w_en;
  logic             w_term;

  // Counting stops at limit_q, so the counter never has to overflow.
  assign w_term = (w_count == r_limit_q);

  // Counter controls, following the same priority as the FSM:
  // stop > start > pause > terminal-count.
  always_comb begin
    w_clr = 1'b0;
    w_en  = 1'b0;
    case (r_state)
      IDLE:    w_clr = bus.start & ~bus.stop;
      RUN: begin
        if (bus.stop)       w_clr = 1'b1;
        else if (bus.pause) w_en  = 1'b0;
        else if (w_term)    w_clr = r_periodic_q;  // one-shot holds at limit
        else                w_en  = 1'b1;
      end
      PAUSED:  w_clr = bus.stop;
      DONE:    w_clr = bus.stop | bus.start;
      default: w_clr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_limit_q    <= '0;
      r_periodic_q <= 1'b0;
      r_done       <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!bus.stop && bus.start) begin
            r_state      <= RUN;
            r_limit_q    <= bus.limit;
            r_periodic_q <= bus.periodic;
          end
        end
        RUN: begin
          if (bus.stop)       r_state <= IDLE;
          else if (bus.pause) r_state <= PAUSED;  // terminal check deferred
          else if (w_term) begin
            if (r_periodic_q) r_wrap <= 1'b1;
            else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        PAUSED: begin
          if (bus.stop)        r_state <= IDLE;
          else if (!bus.pause) r_state <= RUN;
        end
        DONE: begin
          if (!bus.stop && bus.start) begin
            r_state      <= RUN;
            r_limit_q    <= bus.limit;
            r_periodic_q <= bus.periodic;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  timer_count_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_count (w_count)
  );

  assign bus.count = w_count;
  assign bus.state = r_state;
  assign bus.busy  = (r_state == RUN) || (r_state == PAUSED);
  assign bus.done  = r_done;
  assign bus.wrap  = r_wrap;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed scenarios plus randomized traffic for timer_ctrl,
// each edge compared against a behavioural timer model.
module tb_timer_ctrl;
  localparam int W = 3;

  logic clk;
  logic rst_n;

  timer_ctrl_if #(.WIDTH(W)) bus ();

  timer_ctrl #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: a timer is either idle, counting, frozen, or
  // reporting completion for one cycle.
  bit m_active, m_frozen, m_finished;
  int m_cnt, m_lim;
  bit m_per, m_done, m_wrap;

  function automatic void model_reset();
    m_active = 0; m_frozen = 0; m_finished = 0;
    m_cnt = 0; m_lim = 0; m_per = 0; m_done = 0; m_wrap = 0;
  endfunction

  function automatic void model_begin();
    m_active = 1; m_frozen = 0; m_finished = 0;
    m_cnt = 0; m_lim = int'(bus.limit); m_per = bus.periodic;
  endfunction

  function automatic void model_abort();
    m_active = 0; m_frozen = 0; m_finished = 0; m_cnt = 0;
  endfunction

  function automatic void model_step();
    m_done = 0;
    m_wrap = 0;
    if (m_finished) begin
      if (bus.stop)       model_abort();
      else if (bus.start) model_begin();
      else                m_finished = 0;     // count keeps its value
    end else if (!m_active) begin
      if (!bus.stop && bus.start) model_begin();
    end else if (m_frozen) begin
      if (bus.stop)        model_abort();
      else if (!bus.pause) m_frozen = 0;
    end else begin
      if (bus.stop)       model_abort();
      else if (bus.pause) m_frozen = 1;
      else if (m_cnt == m_lim) begin
        if (m_per) begin m_cnt = 0; m_wrap = 1; end
        else begin m_active = 0; m_finished = 1; m_done = 1; end
      end else m_cnt = m_cnt + 1;
    end
  endfunction

  function automatic int exp_state();
    if (m_finished) return 3;
    if (!m_active)  return 0;
    if (m_frozen)   return 2;
    return 1;
  endfunction

  task automatic compare_all();
    chk("count", 32'(bus.count), 32'(m_cnt));
    chk("state", 32'(bus.state), 32'(exp_state()));
    chk("busy",  32'(bus.busy),  32'(m_active));
    chk("done",  32'(bus.done),  32'(m_done));
    chk("wrap",  32'(bus.wrap),  32'(m_wrap));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic start_run(input int lim, input bit per);
    bus.start = 1'b1; bus.limit = W'(lim); bus.periodic = per;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.limit = '0; bus.periodic = 0;
    model_reset();
    #12;
    compare_all();
    rst_n = 1'b1;

    // 1: async reset mid-run, between edges
    start_run(7, 0);
    repeat (4) tick();
    chk("t1_count4", 32'(bus.count), 32'd4);
    rst_n = 1'b0;
    #2;
    chk("t1_rst_count", 32'(bus.count), 32'd0);
    chk("t1_rst_state", 32'(bus.state), 32'd0);
    chk("t1_rst_busy",  32'(bus.busy),  32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    repeat (3) tick();

    // 2: one-shot limit=5
    start_run(5, 0);
    repeat (5) tick();
    tick();
    chk("t2_done", 32'(bus.done), 32'd1);
    chk("t2_hold", 32'(bus.count), 32'd5);
    tick();
    chk("t2_idle", 32'(bus.state), 32'd0);
    chk("t2_keep", 32'(bus.count), 32'd5);

    // 3: periodic limit=2
    start_run(2, 1);
    repeat (8) tick();
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;

    // 4: pause at count 3
    start_run(7, 0);
    repeat (3) tick();
    bus.pause = 1'b1;
    repeat (4) tick();
    chk("t4_paused", 32'(bus.state), 32'd2);
    chk("t4_frozen", 32'(bus.count), 32'd3);
    bus.pause = 1'b0;
    tick();
    chk("t4_resume", 32'(bus.state), 32'd1);
    tick();
    chk("t4_next", 32'(bus.count), 32'd4);
    repeat (3) tick();
    tick();
    chk("t4_done", 32'(bus.done), 32'd1);
    tick();

    // 5: stop beats start; limit=0 one-shot; back-to-back start from DONE
    start_run(7, 0);
    repeat (4) tick();
    bus.stop = 1'b1; bus.start = 1'b1;
    tick();
    bus.stop = 1'b0; bus.start = 1'b0;
    chk("t5_stop", 32'(bus.state), 32'd0);
    start_run(0, 0);
    tick();
    chk("t5_done0", 32'(bus.done), 32'd1);
    bus.start = 1'b1; bus.limit = 3'd3;
    tick();
    bus.start = 1'b0;
    chk("t5_b2b", 32'(bus.state), 32'd1);
    repeat (5) tick();

    // 6: full range, limit change mid-run ignored
    start_run(7, 0);
    bus.limit = 3'd2;
    repeat (7) tick();
    chk("t6_max", 32'(bus.count), 32'd7);
    tick();
    chk("t6_done", 32'(bus.done), 32'd1);
    tick();

    // limit=0 periodic: wrap every cycle
    start_run(0, 1);
    repeat (4) tick();
    chk("lim0_wrap", 32'(bus.wrap), 32'd1);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;

    // randomized traffic
    repeat (500) begin
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.stop     = ($urandom_range(0, 15) == 0);
      bus.pause    = ($urandom_range(0, 4) == 0);
      bus.limit    = W'($urandom_range(0, 7));
      bus.periodic = $urandom_range(0, 1) == 1;
      tick();
      chk("excl", 32'(bus.done & bus.wrap), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
